serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 4, operand/result bit width (legal range 2..16).
REQ-002 Port clk SHALL be: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be: rst  input  1  reset, synchronous, active-high.
REQ-004 Port start SHALL be: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port a SHALL be: a  input  WIDTH  minuend, unsigned; captured on accepted start.
REQ-006 Port b SHALL be: b  input  WIDTH  subtrahend, unsigned; captured on accepted start.
REQ-007 Port busy SHALL be: busy  output  1  high while in SHIFT or DONE.
REQ-008 Port out_valid SHALL be: out_valid  output  1  result valid, held until acknowledged.
REQ-009 Port out_ack SHALL be: out_ack  input  1  consumer acknowledge of the result.
REQ-010 Port diff SHALL be: diff  output  WIDTH  (a - b) mod 2^WIDTH.
REQ-011 Port bout SHALL be: bout  output  1  final borrow; 1 iff a < b (unsigned).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1, the block SHALL capture a and b into internal shift registers, clear the borrow flop and the bit counter, and go to SHIFT.
REQ-014 Each SHIFT cycle SHALL process one bit, LSB first, through a single full-subtractor: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-015 Each SHIFT cycle SHALL shift the a and b registers right by one and insert d at the MSB of a partial-difference register shifted right.
REQ-016 SHIFT SHALL last exactly WIDTH cycles, counted by a counter of width clog2(WIDTH+1); on the WIDTH-th bit the FSM SHALL go to DONE.
REQ-017 On entry to DONE, diff and bout SHALL load the completed difference and final borrow, and out_valid SHALL go high.
REQ-018 Latency SHALL be fixed: with start sampled at edge 0, out_valid SHALL first be high after edge WIDTH+1.
REQ-019 In DONE, out_valid, diff and bout SHALL hold stable until an edge with out_ack=1, after which the FSM SHALL return to IDLE and out_valid SHALL drop.
REQ-020 diff and bout SHALL keep their last value in IDLE and SHIFT and SHALL change only on entry to DONE or on reset.
REQ-021 start SHALL be ignored in SHIFT and DONE; captured operands SHALL not be affected by changes on a or b after acceptance.
REQ-022 When start and out_ack are both high in DONE, the ack SHALL be honoured and the start SHALL be ignored; the next start SHALL be accepted no earlier than the following cycle in IDLE.
REQ-023 out_ack outside DONE SHALL have no effect.
REQ-024 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-025 With rst=1 at a rising edge, the state SHALL become IDLE, and busy, out_valid, diff, bout, the borrow flop, the counter and the shift registers SHALL all become 0.
REQ-026 rst SHALL override start and out_ack in the same cycle.
REQ-027 rst in SHIFT or DONE SHALL abort the operation with no out_valid pulse, and the aborted result SHALL never appear on diff.

Verification
REQ-028 WIDTH=4, a=0110, b=0001, start for 1 cycle -> out_valid after edge 5, diff=0101, bout=0; busy high for edges 1..5 and until ack.
REQ-029 Back-to-back vectors with immediate ack: (0011,0100) -> 1111/1; (1000,1100) -> 1100/1; (1111,1111) -> 0000/0; (0000,0000) -> 0000/0; (1110,0011) -> 1011/0.
REQ-030 Hold: a=1000, b=1111, ack withheld 10 cycles -> diff=1001, bout=1, out_valid stable for all 10 cycles, and a start pulse mid-hold is ignored.
REQ-031 Operand change and restart: change a and b and pulse start during SHIFT -> result reflects only the originally captured operands; then start with out_ack in the same DONE cycle -> no new operation until start is reasserted in IDLE.
REQ-032 Reset mid-operation: rst at the 2nd SHIFT cycle -> all outputs 0 on the next edge, no out_valid; a following fresh start (0011,0100) -> 1111/1 at nominal latency.
REQ-033 Exhaustive: all 256 (a,b) pairs at WIDTH=4 -> {bout,diff} == ({1'b0,a} - {1'b0,b}) mod 32 for every pair.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor step per cycle, LSB first,
// with a valid/ack handshake holding the result until the consumer takes it.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, pd;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, br_nx;

  function automatic logic fs_diff(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  always_comb begin
    d     = fs_diff(sa[0], sb[0], br);
    br_nx = fs_borrow(sa[0], sb[0], br);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    if (out_valid && out_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      sa        <= '0;
      sb        <= '0;
      pd        <= '0;
      br        <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            pd  <= '0;
            br  <= 1'b0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          pd  <= {d, pd[WIDTH-1:1]};
          br  <= br_nx;
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          // First DONE cycle publishes the result; ack only counts once it is visible.
          if (!out_valid) begin
            diff      <= pd;
            bout      <= br;
            out_valid <= 1'b1;
          end else if (out_ack) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor with a queue-based scoreboard.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, out_ack;
  logic [W-1:0] a, b;
  logic         busy, out_valid, bout;
  logic [W-1:0] diff;

  int           ncmp = 0;
  int           nfail = 0;
  logic [W:0]   exp_q[$];
  logic         prev_v = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .out_valid(out_valid), .out_ack(out_ack),
    .diff(diff), .bout(bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compare each newly presented result against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("result", {27'd0, bout, diff}, {27'd0, e});
      end
    end
    prev_v <= out_valid;
  end

  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input int hold,
                       input bit disturb, input bit start_with_ack);
    logic [W:0] e;
    int n;
    e = ({1'b0, va} - {1'b0, vb}) % 32;
    start = 1'b1; a = va; b = vb;
    exp_q.push_back(e);
    @(negedge clk); start = 1'b0; n = 1;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    if (disturb) begin
      a = ~va; b = ~vb; start = 1'b1;
      @(negedge clk); start = 1'b0; n++;
      a = W'($urandom); b = W'($urandom);
    end
    while (!out_valid && n < 20) begin
      @(negedge clk); n++;
      if (!out_valid) chk("busy_shift", {31'd0, busy}, 32'd1);
    end
    chk("latency", n, W + 2);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_value", {27'd0, bout, diff}, {27'd0, e});
      if (i == hold / 2) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom);
      end
      @(negedge clk); start = 1'b0;
    end
    out_ack = 1'b1;
    if (start_with_ack) start = 1'b1;
    @(negedge clk); out_ack = 1'b0; start = 1'b0;
    chk("ack_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("ack_idle", {31'd0, busy}, 32'd0);
    chk("ack_keep_diff", {27'd0, bout, diff}, {27'd0, e});
    if (start_with_ack) begin
      @(negedge clk);
      chk("no_restart", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; out_ack = 1'b1; a = '1; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {27'd0, bout, diff}, 32'd0);
    rst = 1'b0; start = 1'b0; out_ack = 1'b0;
    @(negedge clk);

    // Basic vector with operand changes during SHIFT.
    do_op(4'b0110, 4'b0001, 0, 1'b1, 1'b0);

    // Back-to-back with immediate ack.
    do_op(4'b0011, 4'b0100, 0, 1'b0, 1'b0);
    do_op(4'b1000, 4'b1100, 0, 1'b0, 1'b0);
    do_op(4'b1111, 4'b1111, 0, 1'b0, 1'b0);
    do_op(4'b0000, 4'b0000, 0, 1'b0, 1'b0);
    do_op(4'b1110, 4'b0011, 0, 1'b0, 1'b0);

    // Long hold with a start pulse in the middle, then start coinciding with ack.
    do_op(4'b1000, 4'b1111, 10, 1'b0, 1'b0);
    do_op(4'b0101, 4'b1010, 2, 1'b1, 1'b1);

    // Ack while idle does nothing.
    out_ack = 1'b1;
    repeat (2) @(negedge clk);
    out_ack = 1'b0;
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);
    chk("idle_ack_valid", {31'd0, out_valid}, 32'd0);

    // Reset during the second SHIFT cycle aborts silently.
    start = 1'b1; a = 4'b0101; b = 4'b1001;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1; out_ack = 1'b1;
    @(negedge clk); rst = 1'b0; out_ack = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out", {27'd0, bout, diff}, 32'd0);
    repeat (W + 3) @(negedge clk);
    chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    do_op(4'b0011, 4'b0100, 0, 1'b0, 1'b0);

    // Exhaustive sweep.
    for (int i = 0; i < 256; i++)
      do_op(W'(i >> 4), W'(i & 15), 0, 1'b0, 1'b0);

    // Random operands, holds and disturbances.
    for (int k = 0; k < 60; k++)
      do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 4)),
            1'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
